sine_ram_axil_slave: RTL and testbench

AXI4-Lite slave responder for the SINE_RAM IP. It answers the bus-master traffic the IP's BFM bench issues: single-beat writes and reads to four 32-bit control registers and a 256 x 16-bit sample RAM window. A phase-accumulator generator reads the sample RAM and streams samples on a valid/ready output. The block sits directly behind the S00_AXI port of the IP wrapper.

---
 rtl/sine_ram_axil_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_sine_ram_axil_slave.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_ram_axil_slave.sv
// AXI4-Lite slave for the SINE_RAM IP. It provides four control registers and a
// 256-entry sample RAM, and a phase-accumulator generator streams samples from that RAM.
module sine_ram_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 11,
  parameter int C_SAMPLE_WIDTH     = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_SAMPLE_WIDTH-1:0]         sample_out,
  output logic                              sample_valid,
  input  logic                              sample_ready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = C_SAMPLE_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic       {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;
  typedef enum logic [1:0] {SEL_REG, SEL_RAM, SEL_NONE} sel_t;

  // Upper half of the map is the RAM window; only the first 16 bytes of the lower half are registers.
  function automatic sel_t decode(input logic [AW-1:4] a);
    if (a[AW-1])             return SEL_RAM;
    else if (a[AW-2:4] == '0) return SEL_REG;
    else                     return SEL_NONE;
  endfunction

  // regs[0]=CTRL, regs[1]=PHASE_INC, regs[2]=PHASE_OFS, regs[3]=SCRATCH
  logic [DW-1:0] regs [4];
  logic [SW-1:0] ram  [256];

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  // ---------------- write channel ----------------
  logic              aw_held, w_held;
  logic [AW-1:0]     awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic              aw_hs, w_hs, wr_commit;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_strb;
  sel_t              wr_sel;

  // A channel handshaking this cycle is used directly, so the write commits in the
  // same cycle as the later handshake and BVALID follows one cycle after it.
  assign wr_addr = aw_held ? awaddr_q : S_AXI_AWADDR;
  assign wr_data = w_held  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_held  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_sel  = decode(wr_addr[AW-1:4]);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    wr_commit     = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = !aw_held;
        S_AXI_WREADY  = !w_held;
        aw_hs         = S_AXI_AWVALID && !aw_held;
        w_hs          = S_AXI_WVALID && !w_held;
        wr_commit     = (aw_held || aw_hs) && (w_held || w_hs);
        if (wr_commit) w_state_next = W_RESP;
      end
      W_RESP:  if (S_AXI_BREADY) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  assign S_AXI_BVALID = (w_state == W_RESP);

  // ---------------- read channel ----------------
  logic          ar_hs, rd_fetch, rd_conflict;
  logic [AW-1:0] araddr_q;
  sel_t          rd_sel;
  logic [SW-1:0] ram_a_rd;

  assign rd_sel   = decode(araddr_q[AW-1:4]);
  assign ram_a_rd = ram[araddr_q[9:2]];
  // A write to the same storage wins the cycle; the fetch retries so it sees the new data.
  assign rd_conflict = wr_commit && (wr_sel == rd_sel) && (rd_sel != SEL_NONE);

  always_comb begin
    r_state_next  = r_state;
    S_AXI_ARREADY = 1'b0;
    ar_hs         = 1'b0;
    rd_fetch      = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        ar_hs         = S_AXI_ARVALID;
        if (ar_hs) r_state_next = R_FETCH;
      end
      R_FETCH: if (!rd_conflict) begin
        rd_fetch     = 1'b1;
        r_state_next = R_RESP;
      end
      R_RESP:  if (S_AXI_RREADY) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  assign S_AXI_RVALID = (r_state == R_RESP);

  // NOTE: sequential state uses non-blocking assignments only, so every block samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        S_AXI_BRESP <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        if (wr_sel == SEL_REG)
          for (int b = 0; b < DW/8; b++)
            if (wr_strb[b]) regs[wr_addr[3:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      araddr_q    <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      if (ar_hs) araddr_q <= S_AXI_ARADDR;
      if (rd_fetch) begin
        case (rd_sel)
          SEL_REG: begin
            S_AXI_RDATA <= regs[araddr_q[3:2]];
            S_AXI_RRESP <= RESP_OKAY;
          end
          SEL_RAM: begin
            S_AXI_RDATA <= {{(DW-SW){ram_a_rd[SW-1]}}, ram_a_rd};
            S_AXI_RRESP <= RESP_OKAY;
          end
          default: begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_SLVERR;
          end
        endcase
      end
    end
  end

  // ---------------- generator ----------------
  logic          gen_en, gen_adv, s1_valid;
  logic [31:0]   phase_acc, phase_sum;
  logic [7:0]    gen_addr;
  logic [SW-1:0] ram_b_q;

  assign gen_en    = regs[0][0];
  assign phase_sum = phase_acc + regs[2];
  assign gen_addr  = phase_sum[31:24];
  assign gen_adv   = gen_en && (!sample_valid || sample_ready);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      phase_acc    <= '0;
      s1_valid     <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else if (!gen_en) begin
      phase_acc    <= '0;
      s1_valid     <= 1'b0;
      sample_valid <= 1'b0;
    end else if (gen_adv) begin
      phase_acc    <= phase_acc + regs[1];
      s1_valid     <= 1'b1;
      sample_valid <= s1_valid;
      sample_out   <= ram_b_q;
    end
  end

  // NOTE: the sample RAM has no reset; its contents survive ARESET and map onto block RAM.
  always_ff @(posedge ACLK) begin
    if (!ARESET && wr_commit && wr_sel == SEL_RAM)
      for (int b = 0; b < SW/8; b++)
        if (wr_strb[b]) ram[wr_addr[9:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
  end

  always_ff @(posedge ACLK) begin
    if (gen_adv) ram_b_q <= ram[gen_addr];
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, phase_sum[23:0],
                       wr_addr[1:0], araddr_q[1:0]};

endmodule

// File: tb/tb_sine_ram_axil_slave.sv
// Self-checking bench for sine_ram_axil_slave: randomized AXI-Lite traffic and generator
// streaming, compared against a behavioural model of the registers, the RAM and the phase sequence.
module tb_sine_ram_axil_slave;

  logic        aclk, areset;
  logic [10:0] s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [15:0] s_sample_out;
  logic        s_sample_valid, s_sample_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [4];
  logic [15:0] m_ram  [256];

  sine_ram_axil_slave dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWPROT(s_awprot), .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARPROT(s_arprot), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
    .sample_out(s_sample_out), .sample_valid(s_sample_valid), .sample_ready(s_sample_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [7:0] idx;
    if (a >= 11'h400) begin
      idx = a[9:2];
      if (s[0]) m_ram[idx][7:0]  = d[7:0];
      if (s[1]) m_ram[idx][15:8] = d[15:8];
      return 2'b00;
    end
    if (a < 11'h010) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[a[3:2]][b*8 +: 8] = d[b*8 +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic void model_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
    if (a >= 11'h400) begin
      d = 32'($signed(m_ram[a[9:2]]));
      r = 2'b00;
    end else if (a < 11'h010) begin
      d = m_regs[a[3:2]];
      r = 2'b00;
    end else begin
      d = 32'h0;
      r = 2'b10;
    end
  endfunction

  // ---------------- bus tasks (all start and end at posedge + 1) ----------------
  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input string tag);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] exp_resp, got_resp;
    aw_done = 0; w_done = 0; cyc = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done && (cyc >= w_dly);
      #1;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge aclk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    s_awvalid = 0; s_wvalid = 0;
    n_checks++;
    if (s_bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wr_bvalid addr=%h got bvalid=%b want 1", tag, addr, s_bvalid);
    end
    exp_resp = model_write(addr, data, strb);
    repeat (b_dly) begin @(posedge aclk); #1; end
    got_resp = s_bresp;
    s_bready = 1;
    @(posedge aclk); #1;
    s_bready = 0;
    n_checks++;
    if (got_resp !== exp_resp) begin
      n_fail++;
      $display("FAIL %s wr_bresp addr=%h got %b want %b", tag, addr, got_resp, exp_resp);
    end
  endtask

  task automatic axi_read(input logic [10:0] addr, input int r_dly, input string tag);
    int cyc;
    bit hs;
    logic [31:0] exp_d, got_d;
    logic [1:0]  exp_r, got_r;
    model_read(addr, exp_d, exp_r);
    s_araddr = addr; s_arvalid = 1; cyc = 0; hs = 0;
    while (!hs && cyc < 40) begin
      #1;
      hs = s_arready;
      @(posedge aclk); #1;
      cyc++;
    end
    s_arvalid = 0;
    n_checks++;
    if (s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rd_fetch addr=%h got rvalid=%b want 0", tag, addr, s_rvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (s_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rd_rvalid addr=%h got rvalid=%b want 1", tag, addr, s_rvalid);
    end
    got_d = s_rdata; got_r = s_rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== got_d || s_rresp !== got_r) begin
        n_fail++;
        $display("FAIL %s rd_stable addr=%h got %b/%h/%b want 1/%h/%b", tag, addr,
                 s_rvalid, s_rdata, s_rresp, got_d, got_r);
      end
    end
    s_rready = 1;
    @(posedge aclk); #1;
    s_rready = 0;
    n_checks++;
    if (got_d !== exp_d || got_r !== exp_r) begin
      n_fail++;
      $display("FAIL %s rd_data addr=%h got %h/%b want %h/%b", tag, addr, got_d, got_r, exp_d, exp_r);
    end
  endtask

  // Consumes n samples; sample k must equal RAM[(k*inc + ofs)[31:24]].
  task automatic collect_samples(input int n, input int ready_pct, input int stall_at,
                                 input logic [31:0] inc, input logic [31:0] ofs, input string tag);
    int k, cyc;
    bit held;
    logic [15:0] held_val, exp;
    logic [31:0] ph;
    k = 0; cyc = 0; held = 0; held_val = '0;
    while (k < n && cyc < 4000) begin
      if (held) begin
        n_checks++;
        if (s_sample_valid !== 1'b1 || s_sample_out !== held_val) begin
          n_fail++;
          $display("FAIL %s gen_stall_hold k=%0d got %b/%h want 1/%h", tag, k, s_sample_valid, s_sample_out, held_val);
        end
      end
      s_sample_ready = ($urandom_range(99) < 32'(ready_pct));
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 4) s_sample_ready = 0;
      #1;
      held = s_sample_valid && !s_sample_ready;
      held_val = s_sample_out;
      if (s_sample_valid && s_sample_ready) begin
        ph  = 32'(k) * inc + ofs;
        exp = m_ram[ph[31:24]];
        n_checks++;
        if (s_sample_out !== exp) begin
          n_fail++;
          $display("FAIL %s gen_sample k=%0d got %h want %h", tag, k, s_sample_out, exp);
        end
        k++;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    n_checks++;
    if (k != n) begin
      n_fail++;
      $display("FAIL %s gen_count got %0d samples want %0d", tag, k, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp} !== 9'b1_1_0_00_1_0_00) begin
      n_fail++;
      $display("FAIL reset_handshake got %b want 110001000",
               {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp});
    end
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h want 0", s_rdata);
    end
    n_checks++;
    if (s_sample_valid !== 1'b0 || s_sample_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_sample got %b/%h want 0/0", s_sample_valid, s_sample_out);
    end
    for (int i = 0; i < 4; i++) axi_read(11'(i * 4), 0, "reset_regs");
  endtask

  task automatic test_regs();
    logic [10:0] a;
    for (int i = 0; i < 4; i++) axi_write(11'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, "regs_seq");
    for (int i = 0; i < 4; i++) axi_read(11'(i * 4), 0, "regs_seq");
    for (int n = 0; n < 20; n++) begin
      a = {7'h0, 2'($urandom_range(3)), 2'($urandom_range(3))};
      axi_write(a, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(3), $urandom_range(2), "regs_rand");
      axi_read({7'h0, 2'($urandom_range(3)), 2'b00}, $urandom_range(2), "regs_rand");
    end
    axi_write(11'h000, 32'h0, 4'hF, 0, 0, 0, "regs_ctrl_off");
    for (int i = 0; i < 4; i++) axi_read(11'(i * 4), 0, "regs_final");
  endtask

  task automatic test_write_timing();
    logic [1:0] resp0;
    s_awaddr = 11'h00C; s_wdata = 32'hCAFE_0123; s_wstrb = 4'hF; s_bready = 0;
    s_awvalid = 1;
    @(posedge aclk); #1;
    s_awvalid = 0;
    n_checks++;
    if ({s_awready, s_wready, s_bvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL wt_aw_latched got aw/w/b=%b want 010", {s_awready, s_wready, s_bvalid});
    end
    @(posedge aclk); #1;
    s_wvalid = 1;
    @(posedge aclk); #1;
    s_wvalid = 0;
    n_checks++;
    if ({s_awready, s_wready, s_bvalid} !== 3'b001) begin
      n_fail++;
      $display("FAIL wt_commit got aw/w/b=%b want 001", {s_awready, s_wready, s_bvalid});
    end
    void'(model_write(11'h00C, 32'hCAFE_0123, 4'hF));
    resp0 = s_bresp;
    repeat (3) begin
      @(posedge aclk); #1;
      n_checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_bresp !== resp0) begin
        n_fail++;
        $display("FAIL wt_bhold got bvalid=%b bresp=%b want 1/00", s_bvalid, s_bresp);
      end
    end
    s_bready = 1;
    @(posedge aclk); #1;
    s_bready = 0;
    n_checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_bclear got bvalid=%b awready=%b want 0/1", s_bvalid, s_awready);
    end
    axi_read(11'h00C, 0, "wt_readback");
    axi_write(11'h008, 32'h1111_2222, 4'hF, 2, 0, 1, "wt_w_first");
    axi_read(11'h008, 0, "wt_w_first");
  endtask

  task automatic test_ram_strobe();
    axi_write(11'h404, 32'h0000_0000, 4'hF, 0, 0, 0, "ram_zero");
    axi_write(11'h404, 32'hFFFF_8001, 4'h1, 0, 0, 0, "ram_strb1");
    axi_read(11'h404, 0, "ram_strb1");
    axi_write(11'h404, 32'hFFFF_8001, 4'hF, 1, 0, 0, "ram_full");
    axi_read(11'h404, 1, "ram_full");
    axi_write(11'h404, 32'h1234_5678, 4'hC, 0, 1, 0, "ram_upper_ignored");
    axi_read(11'h404, 0, "ram_upper_ignored");
    axi_write(11'h7FD, 32'h0000_7F00, 4'h2, 0, 0, 0, "ram_top_strb2");
    axi_read(11'h7FC, 0, "ram_top_strb2");
  endtask

  task automatic test_unmapped();
    axi_write(11'h200, $urandom, 4'hF, 0, 0, 0, "unmap_200");
    axi_read(11'h200, 0, "unmap_200");
    axi_write(11'h010, $urandom, 4'hF, 1, 0, 0, "unmap_010");
    axi_read(11'h3FC, 1, "unmap_3fc");
    for (int n = 0; n < 4; n++) begin
      axi_write(11'($urandom_range(11'h3FF, 11'h010)), $urandom, 4'($urandom), 0, 0, 0, "unmap_rand");
      axi_read(11'($urandom_range(11'h3FF, 11'h010)), 0, "unmap_rand");
    end
    for (int i = 0; i < 4; i++) axi_read(11'(i * 4), 0, "unmap_regs_intact");
  endtask

  task automatic test_generator();
    axi_write(11'h000, 32'h0, 4'hF, 0, 0, 0, "gen_off");
    for (int i = 0; i < 256; i++) axi_write(11'h400 | 11'(i << 2), 32'(i), 4'hF, 0, 0, 0, "gen_fill");
    axi_write(11'h004, 32'h0100_0000, 4'hF, 0, 0, 0, "gen_inc");
    axi_write(11'h008, 32'h0, 4'hF, 0, 0, 0, "gen_ofs");
    s_sample_ready = 1;
    axi_write(11'h000, 32'h1, 4'hF, 0, 0, 0, "gen_on");
    n_checks++;
    if (s_sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gen_first_early got sample_valid=%b want 0", s_sample_valid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (s_sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gen_first_valid got sample_valid=%b want 1", s_sample_valid);
    end
    collect_samples(257, 100, 120, 32'h0100_0000, 32'h0, "gen_ramp");
    axi_write(11'h000, 32'h0, 4'hF, 0, 0, 0, "gen_disable");
    n_checks++;
    if (s_sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gen_disable got sample_valid=%b want 0", s_sample_valid);
    end
  endtask

  task automatic test_random_ram();
    logic [7:0] idx;
    for (int n = 0; n < 24; n++) begin
      idx = 8'($urandom);
      axi_write({1'b1, 2'($urandom), idx, 2'($urandom)}, $urandom, 4'($urandom),
                $urandom_range(2), $urandom_range(2), $urandom_range(2), "ram_rand");
      axi_read({1'b1, 2'($urandom), 8'($urandom), 2'b00}, $urandom_range(2), "ram_rand");
      axi_read({1'b1, 2'b00, idx, 2'b00}, 0, "ram_rand_same");
    end
  endtask

  task automatic test_generator_random();
    logic [31:0] inc, ofs;
    for (int i = 0; i < 256; i++) axi_write(11'h400 | 11'(i << 2), $urandom, 4'hF, 0, 0, 0, "genr_fill");
    for (int t = 0; t < 2; t++) begin
      inc = $urandom; ofs = $urandom;
      axi_write(11'h004, inc, 4'hF, 0, 0, 0, "genr_inc");
      axi_write(11'h008, ofs, 4'hF, 0, 0, 0, "genr_ofs");
      axi_write(11'h000, 32'h1, 4'hF, 0, 0, 0, "genr_on");
      collect_samples(64, 70, -1, inc, ofs, "genr_stream");
      axi_write(11'h000, 32'h0, 4'hF, 0, 0, 0, "genr_off");
      n_checks++;
      if (s_sample_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL genr_disable got sample_valid=%b want 0", s_sample_valid);
      end
    end
  endtask

  task automatic test_reset_abort();
    s_araddr = 11'h008; s_arvalid = 1;
    @(posedge aclk); #1;
    s_arvalid = 0;
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    n_checks++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rfetch got rvalid=%b arready=%b want 0/1", s_rvalid, s_arready);
    end
    s_awaddr = 11'h00C; s_wdata = 32'h1357_9BDF; s_wstrb = 4'hF; s_bready = 0;
    s_awvalid = 1; s_wvalid = 1;
    @(posedge aclk); #1;
    s_awvalid = 0; s_wvalid = 0;
    n_checks++;
    if (s_bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_bvalid got bvalid=%b want 1", s_bvalid);
    end
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    n_checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wresp got bvalid=%b aw=%b w=%b want 0/1/1", s_bvalid, s_awready, s_wready);
    end
    for (int i = 0; i < 4; i++) axi_read(11'(i * 4), 0, "rst_regs_cleared");
    axi_write(11'h00C, 32'hA5A5_5A5A, 4'hF, 1, 0, 1, "rst_after");
    axi_read(11'h00C, 1, "rst_after");
    axi_read({1'b1, 2'b00, 8'($urandom), 2'b00}, 0, "rst_ram_kept");
  endtask

  initial begin
    areset = 1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0; s_sample_ready = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 0;
    test_reset();
    test_regs();
    test_write_timing();
    test_ram_strobe();
    test_unmapped();
    test_generator();
    test_random_ram();
    test_generator_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
